// File: rtl/aes256_key_expand.sv
// AES-256 key schedule: expands one 256-bit cipher key into 15 round keys,
// one 32-bit word per clock, each round key streamed out as a one-cycle pulse.

// Forward AES S-box as a constant lookup table (entry 0x00 in the MSBs).
module aes256_key_expand_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry a sits at bit offset (255-a)*8, i.e. {~a,3'b000}.
  assign y = TBL[{~a, 3'b000} +: 8];
endmodule

module aes256_key_expand (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key,
  output logic         busy,
  output logic         rk_valid,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk,
  output logic         done
);
  localparam int unsigned NK     = 8;
  localparam int unsigned NR     = 14;
  localparam int unsigned NWORDS = 4 * (NR + 1);
  localparam logic [5:0]  ILAST  = 6'(NWORDS - 1);

  typedef enum logic [1:0] {IDLE, RK0, RK1, EXPAND} state_t;

  state_t       state, state_nxt;
  logic [255:0] win;        // w[i-8] in MSBs .. w[i-1] in LSBs
  logic [5:0]   i;
  logic [31:0]  prev, rot, sub_in, sub_out, t, wnew;
  logic [7:0]   rcon;

  assign prev   = win[31:0];
  assign rot    = {prev[23:0], prev[31:24]};
  assign sub_in = (i[2:0] == 3'd0) ? rot : prev;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes256_key_expand_sbox u_sbox (
      .a (sub_in[8*g +: 8]),
      .y (sub_out[8*g +: 8])
    );
  end

  // Round constant selected by the round counter i/NK.
  always_comb begin
    rcon = 8'h00;
    case (i[5:3])
      3'd1:    rcon = 8'h01;
      3'd2:    rcon = 8'h02;
      3'd3:    rcon = 8'h04;
      3'd4:    rcon = 8'h08;
      3'd5:    rcon = 8'h10;
      3'd6:    rcon = 8'h20;
      3'd7:    rcon = 8'h40;
      default: rcon = 8'h00;
    endcase
  end

  // Temp word transform and the next schedule word w[i].
  always_comb begin
    t = prev;
    if (i[2:0] == 3'd0)      t = sub_out ^ {rcon, 24'h0};
    else if (i[2:0] == 3'd4) t = sub_out;
    wnew = win[32*NK-1 -: 32] ^ t;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RK0;
      RK0:     state_nxt = RK1;
      RK1:     state_nxt = EXPAND;
      EXPAND:  if (i == ILAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, key window, word counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      win      <= '0;
      i        <= '0;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      rk_idx   <= '0;
      rk       <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      rk_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            win  <= key;
            i    <= 6'(NK);
            busy <= 1'b1;
          end
        end
        RK0: begin
          rk       <= win[255:128];
          rk_idx   <= 4'd0;
          rk_valid <= 1'b1;
        end
        RK1: begin
          rk       <= win[127:0];
          rk_idx   <= 4'd1;
          rk_valid <= 1'b1;
        end
        EXPAND: begin
          win <= {win[223:0], wnew};
          i   <= i + 6'd1;
          // Last word of a round key: the other three are still in the window.
          if (i[1:0] == 2'd3) begin
            rk       <= {win[95:0], wnew};
            rk_idx   <= i[5:2];
            rk_valid <= 1'b1;
          end
          if (i == ILAST) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes256_key_expand.sv
// Directed bench for aes256_key_expand using FIPS-197 A.3 and all-zero key vectors.
module tb_aes256_key_expand;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [255:0] key = '0;
  logic         busy, rk_valid, done;
  logic [3:0]   rk_idx;
  logic [127:0] rk;

  int total = 0;
  int bad   = 0;

  localparam logic [255:0] A3K  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] A3R0 = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] A3R1 = 128'h1f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] A3R2 = 128'h9ba354118e6925afa51a8b5f2067fcde;
  localparam logic [127:0] A3R3 = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
  localparam logic [127:0] A3RE = 128'hfe4890d1e6188d0b046df344706c631e;
  localparam logic [127:0] Z2   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z3   = 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb;

  aes256_key_expand dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key      (key),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_idx   (rk_idx),
    .rk       (rk),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: plain, 1: restart pulses at E10/E30, 2: key changes every cycle,
  // 3: start held high throughout. chk14 enables the rk14 value check.
  task automatic run_stream(input string name, input logic [255:0] k, input int mode,
                            input logic [127:0] x0, input logic [127:0] x1,
                            input logic [127:0] x2, input logic [127:0] x3,
                            input logic [127:0] x14, input bit chk14);
    int np;
    int expe;
    np = 0;
    key   = k;
    start = 1'b1;
    tick();                                   // E0
    check({name, " busy@E0"}, 128'(busy), 128'd1);
    if (mode != 3) start = 1'b0;
    for (int e = 1; e <= 54; e++) begin
      if (mode == 1) begin
        start = (e == 10 || e == 30);
        key   = ~k;
      end else if (mode == 2) begin
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      end
      tick();
      check($sformatf("%s done@E%0d", name, e), 128'(done), 128'(e == 54));
      check($sformatf("%s busy@E%0d", name, e), 128'(busy), 128'(e < 54));
      if (rk_valid) begin
        expe = (np < 2) ? np + 1 : 4 * np - 2;
        check($sformatf("%s idx#%0d", name, np), 128'(rk_idx), 128'(np));
        check($sformatf("%s edge#%0d", name, np), 128'(e), 128'(expe));
        case (np)
          0: check({name, " rk0"}, rk, x0);
          1: check({name, " rk1"}, rk, x1);
          2: check({name, " rk2"}, rk, x2);
          3: check({name, " rk3"}, rk, x3);
          14: if (chk14) check({name, " rk14"}, rk, x14);
          default: ;
        endcase
        np++;
      end
    end
    if (mode == 1) start = 1'b0;
    check({name, " pulses"}, 128'(np), 128'd15);
  endtask

  initial begin
    int cnt;
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst busy", 128'(busy), 128'd0);
    check("rst rk_valid", 128'(rk_valid), 128'd0);
    check("rst rk_idx", 128'(rk_idx), 128'd0);
    check("rst rk", rk, 128'd0);
    check("rst done", 128'(done), 128'd0);
    rst = 1'b0;
    tick();

    // 1: zero key
    run_stream("zero", '0, 0, '0, '0, Z2, Z3, '0, 1'b0);
    tick();
    // 2: FIPS-197 A.3
    run_stream("a3", A3K, 0, A3R0, A3R1, A3R2, A3R3, A3RE, 1'b1);
    tick();
    // 3: start pulses while busy are ignored
    run_stream("restart", A3K, 1, A3R0, A3R1, A3R2, A3R3, A3RE, 1'b1);
    tick();
    check("idle after restart", 128'(busy), 128'd0);

    // 4: reset mid-expansion at E20
    key   = A3K;
    start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    for (int e = 1; e < 20; e++) tick();
    rst = 1'b1;
    tick();                                   // E20
    check("midrst busy", 128'(busy), 128'd0);
    check("midrst rk_valid", 128'(rk_valid), 128'd0);
    check("midrst rk_idx", 128'(rk_idx), 128'd0);
    check("midrst rk", rk, 128'd0);
    check("midrst done", 128'(done), 128'd0);
    rst = 1'b0;
    cnt = 0;
    for (int e = 0; e < 60; e++) begin
      tick();
      if (rk_valid || done || busy) cnt++;
    end
    check("midrst quiet", 128'(cnt), 128'd0);
    run_stream("postrst", A3K, 0, A3R0, A3R1, A3R2, A3R3, A3RE, 1'b1);
    tick();

    // 5: back-to-back with start held high
    run_stream("b2b_1", A3K, 3, A3R0, A3R1, A3R2, A3R3, A3RE, 1'b1);
    run_stream("b2b_2", '0, 3, '0, '0, Z2, Z3, '0, 1'b0);
    start = 1'b0;
    tick();
    check("b2b idle", 128'(busy), 128'd0);

    // 6: key changing every cycle after E0
    run_stream("keychg", A3K, 2, A3R0, A3R1, A3R2, A3R3, A3RE, 1'b1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
